// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bus between the ID stage and the register scoreboard.
// The ID stage (master) drives issue and writeback info and receives stall and status.
interface reg_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
);
    logic              issue_valid_i;
    logic [ADDR_W-1:0] issue_rs1_i;
    logic              issue_rs1_re_i;
    logic [ADDR_W-1:0] issue_rs2_i;
    logic              issue_rs2_re_i;
    logic [ADDR_W-1:0] issue_rd_i;
    logic              issue_we_i;
    logic              issue_long_i;
    logic              flush_i;
    logic              wb_valid_i;
    logic [ADDR_W-1:0] wb_rd_i;
    logic              stall_o;
    logic              busy_o;
    logic [CNT_W-1:0]  pend_cnt_o;
    logic              wb_err_o;

    modport master (
        output issue_valid_i, issue_rs1_i, issue_rs1_re_i, issue_rs2_i, issue_rs2_re_i,
               issue_rd_i, issue_we_i, issue_long_i, flush_i, wb_valid_i, wb_rd_i,
        input  stall_o, busy_o, pend_cnt_o, wb_err_o
    );

    modport slave (
        input  issue_valid_i, issue_rs1_i, issue_rs1_re_i, issue_rs2_i, issue_rs2_re_i,
               issue_rd_i, issue_we_i, issue_long_i, flush_i, wb_valid_i, wb_rd_i,
        output stall_o, busy_o, pend_cnt_o, wb_err_o
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency producers (loads, divider).
// Stalls issue on RAW/WAW against registers whose result does not exist yet.
module reg_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  sb
);

    logic [REG_NUM-1:1] pend_q;
    logic [REG_NUM-1:1] pend_nxt;
    logic [REG_NUM-1:0] pend_full;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               err_q;
    logic               err_nxt;
    logic               wb_hit;
    logic               eff_rs1;
    logic               eff_rs2;
    logic               eff_rd;
    logic               raw;
    logic               waw;
    logic               stall;
    logic               acc;

    // x0 is folded in as a constant zero so every address can index the vector.
    assign pend_full = {pend_q, 1'b0};
    assign wb_hit    = sb.wb_valid_i & (sb.wb_rd_i != '0);

    // A same-cycle writeback is bypassed through the register file, so it masks the pending bit.
    assign eff_rs1 = pend_full[sb.issue_rs1_i] & ~(sb.wb_valid_i & (sb.wb_rd_i == sb.issue_rs1_i));
    assign eff_rs2 = pend_full[sb.issue_rs2_i] & ~(sb.wb_valid_i & (sb.wb_rd_i == sb.issue_rs2_i));
    assign eff_rd  = pend_full[sb.issue_rd_i]  & ~(sb.wb_valid_i & (sb.wb_rd_i == sb.issue_rd_i));

    assign raw = (sb.issue_rs1_re_i & (sb.issue_rs1_i != '0) & eff_rs1)
               | (sb.issue_rs2_re_i & (sb.issue_rs2_i != '0) & eff_rs2);
    assign waw = sb.issue_we_i & (sb.issue_rd_i != '0) & eff_rd;

    assign stall = sb.issue_valid_i & ~sb.flush_i & (raw | waw);
    assign acc   = sb.issue_valid_i & ~sb.flush_i & ~stall & sb.issue_we_i
                 & sb.issue_long_i & (sb.issue_rd_i != '0);

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        pend_nxt = pend_q;
        cnt_nxt  = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            // Set wins over clear: the newly issued op is the register's new owner.
            pend_nxt[i] = (pend_q[i] & ~(wb_hit & (sb.wb_rd_i == ADDR_W'(i))))
                        | (acc & (sb.issue_rd_i == ADDR_W'(i)));
            cnt_nxt     = cnt_nxt + CNT_W'(pend_nxt[i]);
        end
        err_nxt = err_q
                | (wb_hit & ~pend_full[sb.wb_rd_i] & ~(acc & (sb.issue_rd_i == sb.wb_rd_i)));
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous and clears the whole vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_nxt;
            cnt_q  <= cnt_nxt;
            busy_q <= |pend_nxt;
            err_q  <= err_nxt;
        end
    end

    assign sb.stall_o    = stall;
    assign sb.busy_o     = busy_q;
    assign sb.pend_cnt_o = cnt_q;
    assign sb.wb_err_o   = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a reference model predicts status outputs,
// which are queued at drive time and compared after the clock edge.
module tb_reg_scoreboard;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 6;

    typedef struct {
        string tag;
        int    cnt;
        bit    busy;
        bit    err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    bit   m_pend[REG_NUM];
    bit   m_err;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    reg_scoreboard #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid_i  = 1'b0;
        bus.issue_rs1_i    = '0;
        bus.issue_rs1_re_i = 1'b0;
        bus.issue_rs2_i    = '0;
        bus.issue_rs2_re_i = 1'b0;
        bus.issue_rd_i     = '0;
        bus.issue_we_i     = 1'b0;
        bus.issue_long_i   = 1'b0;
        bus.flush_i        = 1'b0;
        bus.wb_valid_i     = 1'b0;
        bus.wb_rd_i        = '0;
    endtask

    task automatic issue(input int rd, input bit we, input bit lng,
                         input int rs1, input bit re1, input int rs2, input bit re2);
        bus.issue_valid_i  = 1'b1;
        bus.issue_rd_i     = ADDR_W'(rd);
        bus.issue_we_i     = we;
        bus.issue_long_i   = lng;
        bus.issue_rs1_i    = ADDR_W'(rs1);
        bus.issue_rs1_re_i = re1;
        bus.issue_rs2_i    = ADDR_W'(rs2);
        bus.issue_rs2_re_i = re2;
    endtask

    task automatic wb(input int rd);
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = ADDR_W'(rd);
    endtask

    function automatic bit eff(input int r);
        return (r != 0) && m_pend[r] && !(bus.wb_valid_i && int'(bus.wb_rd_i) == r);
    endfunction

    // Inputs are already applied (after a falling edge). Check stall, predict and push
    // the registered outputs, then clock and pop/compare after the rising edge.
    task automatic cycle(input string tag);
        bit   m_stall, m_acc;
        int   rd, wrd, cnt;
        exp_t e;
        #1;
        rd  = int'(bus.issue_rd_i);
        wrd = int'(bus.wb_rd_i);
        m_stall = bus.issue_valid_i && !bus.flush_i &&
                  ((bus.issue_rs1_re_i && eff(int'(bus.issue_rs1_i))) ||
                   (bus.issue_rs2_re_i && eff(int'(bus.issue_rs2_i))) ||
                   (bus.issue_we_i && eff(rd)));
        m_acc = bus.issue_valid_i && !bus.flush_i && !m_stall && bus.issue_we_i &&
                bus.issue_long_i && rd != 0;
        if (!rst) check({tag, "_stall"}, 32'(bus.stall_o), 32'(m_stall));
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_err = 1'b0;
        end else begin
            if (bus.wb_valid_i && wrd != 0 && !m_pend[wrd] && !(m_acc && rd == wrd)) m_err = 1'b1;
            if (bus.wb_valid_i && wrd != 0) m_pend[wrd] = 1'b0;
            if (m_acc) m_pend[rd] = 1'b1;
        end
        cnt = 0;
        foreach (m_pend[i]) cnt += int'(m_pend[i]);
        e.tag = tag; e.cnt = cnt; e.busy = (cnt != 0); e.err = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.tag, "_cnt"},  32'(bus.pend_cnt_o), 32'(e.cnt));
        check({e.tag, "_busy"}, 32'(bus.busy_o),     32'(e.busy));
        check({e.tag, "_err"},  32'(bus.wb_err_o),   32'(e.err));
        @(negedge clk);
        idle();
    endtask

    initial begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_err = 1'b0;
        idle();
        rst = 1'b1;
        @(negedge clk);

        // Reset with a writeback in flight, then a writeback to an untracked register.
        for (int i = 0; i < 2; i++) begin
            wb(5);
            cycle("rst_wb");
        end
        check("rst_cnt", 32'(bus.pend_cnt_o), 0);
        check("rst_err", 32'(bus.wb_err_o), 0);
        rst = 1'b0;
        wb(5);
        cycle("wb_untracked");
        check("wb_err_set", 32'(bus.wb_err_o), 1);
        rst = 1'b1;
        cycle("rst_clear_err");
        rst = 1'b0;

        // Load-use RAW on x3, resolved by the writeback.
        issue(3, 1, 1, 0, 0, 0, 0);
        cycle("ld_x3");
        check("ld_x3_cnt1", 32'(bus.pend_cnt_o), 1);
        for (int i = 0; i < 3; i++) begin
            issue(4, 1, 0, 3, 1, 0, 0);
            #1 check("raw_stall", 32'(bus.stall_o), 1);
            cycle("raw_hold");
        end
        issue(4, 1, 0, 3, 1, 0, 0);
        wb(3);
        #1 check("raw_wb_bypass", 32'(bus.stall_o), 0);
        cycle("raw_wb");
        check("raw_cnt0", 32'(bus.pend_cnt_o), 0);

        // WAW: back-to-back stall, then same-cycle set and clear of x7.
        issue(7, 1, 1, 0, 0, 0, 0);
        cycle("ld_x7");
        issue(7, 1, 1, 0, 0, 0, 0);
        #1 check("waw_stall", 32'(bus.stall_o), 1);
        cycle("waw_hold");
        issue(7, 1, 1, 0, 0, 0, 0);
        wb(7);
        #1 check("waw_setclr_stall", 32'(bus.stall_o), 0);
        cycle("waw_setclr");
        check("waw_setclr_cnt", 32'(bus.pend_cnt_o), 1);
        wb(7);
        cycle("wb_x7");
        check("wb_x7_cnt", 32'(bus.pend_cnt_o), 0);
        check("wb_x7_noerr", 32'(bus.wb_err_o), 0);

        // x0 destination, x0 writeback, and read-enable gating.
        issue(0, 1, 1, 0, 0, 0, 0);
        cycle("ld_x0");
        check("x0_cnt", 32'(bus.pend_cnt_o), 0);
        wb(0);
        cycle("wb_x0");
        issue(4, 1, 1, 0, 0, 0, 0);
        cycle("ld_x4");
        issue(0, 0, 0, 0, 0, 4, 0);
        #1 check("rs2_re0", 32'(bus.stall_o), 0);
        cycle("rs2_re0");
        issue(0, 0, 0, 0, 0, 4, 1);
        #1 check("rs2_re1", 32'(bus.stall_o), 1);
        cycle("rs2_re1");
        wb(4);
        cycle("wb_x4");

        // Flush suppresses stall and set but keeps pending bits.
        issue(9, 1, 1, 0, 0, 0, 0);
        cycle("ld_x9");
        issue(10, 1, 1, 9, 1, 0, 0);
        bus.flush_i = 1'b1;
        #1 check("flush_stall", 32'(bus.stall_o), 0);
        cycle("flush");
        check("flush_cnt", 32'(bus.pend_cnt_o), 1);
        issue(0, 0, 0, 9, 1, 0, 0);
        cycle("after_flush");
        wb(9);
        cycle("wb_x9");

        // Multiple outstanding, spurious writeback, set/clear of different registers.
        issue(1, 1, 1, 0, 0, 0, 0);  cycle("ld_x1");
        issue(2, 1, 1, 0, 0, 0, 0);  cycle("ld_x2");
        issue(31, 1, 1, 0, 0, 0, 0); cycle("ld_x31");
        check("multi_cnt3", 32'(bus.pend_cnt_o), 3);
        wb(2);
        cycle("wb_x2");
        check("multi_cnt2", 32'(bus.pend_cnt_o), 2);
        check("multi_busy", 32'(bus.busy_o), 1);
        wb(10);
        cycle("wb_spurious");
        check("spurious_err", 32'(bus.wb_err_o), 1);
        issue(5, 1, 1, 0, 0, 0, 0);
        wb(1);
        cycle("set_clr_diff");
        check("set_clr_diff_cnt", 32'(bus.pend_cnt_o), 2);
        check("err_sticky", 32'(bus.wb_err_o), 1);

        // Reset mid-operation, then a writeback for the now-untracked x31.
        rst = 1'b1;
        wb(31);
        cycle("rst_mid");
        rst = 1'b0;
        wb(31);
        cycle("wb_after_rst");
        check("wb_after_rst_err", 32'(bus.wb_err_o), 1);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
